// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: OUT/DIR/IN registers, set/clear writes, 2-flop input sync.
// Optional edge-triggered interrupts are built only when GPIO_IRQ_EN is defined.
module gpio_ctrl #(
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gpio_en_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       wmem_data_i,
  output logic [31:0]       gpio_data_o,
  input  logic [GPIO_W-1:0] gpio_pins_i,
  output logic [GPIO_W-1:0] gpio_pins_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);

  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_DIR      = 3'd1,
    REG_IN       = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_RISE = 3'd4,
    REG_IRQ_STAT = 3'd5,
    REG_OUT_SET  = 3'd6,
    REG_OUT_CLR  = 3'd7
  } reg_e;

  reg_e              sel;
  logic              wr;
  logic              rd;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] out_q;
  logic [GPIO_W-1:0] dir_q;
  logic [GPIO_W-1:0] sync1_q;
  logic [GPIO_W-1:0] sync2_q;
  logic [31:0]       rd_word;
  logic              unused;

  assign sel    = reg_e'(mem_addr_i[4:2]);
  assign wr     = gpio_en_i & mem_we_i;
  assign rd     = gpio_en_i & ~mem_we_i;
  assign wdata  = wmem_data_i[GPIO_W-1:0];
  // Only address bits [4:2] and the low GPIO_W data bits carry meaning.
  assign unused = ^{mem_addr_i, wmem_data_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr) begin
      case (sel)
        REG_OUT:     out_q <= wdata;
        REG_DIR:     dir_q <= wdata;
        REG_OUT_SET: out_q <= out_q | wdata;
        REG_OUT_CLR: out_q <= out_q & ~wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_pins_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] irq_en_q;
  logic [GPIO_W-1:0] irq_rise_q;
  logic [GPIO_W-1:0] irq_stat_q;
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] hit;
  logic [GPIO_W-1:0] w1c;

  assign hit = (irq_rise_q & sync2_q & ~prev_q) | (~irq_rise_q & ~sync2_q & prev_q);
  assign w1c = (wr && sel == REG_IRQ_STAT) ? wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
    end else begin
      prev_q <= sync2_q;
      // A hardware hit in the same cycle as a W1C keeps the bit set.
      irq_stat_q <= (irq_stat_q & ~w1c) | hit;
      if (wr && sel == REG_IRQ_EN)   irq_en_q   <= wdata;
      if (wr && sel == REG_IRQ_RISE) irq_rise_q <= wdata;
    end
  end

  assign irq_o = |(irq_stat_q & irq_en_q);
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_OUT:      rd_word[GPIO_W-1:0] = out_q;
      REG_DIR:      rd_word[GPIO_W-1:0] = dir_q;
      REG_IN:       rd_word[GPIO_W-1:0] = sync2_q;
`ifdef GPIO_IRQ_EN
      REG_IRQ_EN:   rd_word[GPIO_W-1:0] = irq_en_q;
      REG_IRQ_RISE: rd_word[GPIO_W-1:0] = irq_rise_q;
      REG_IRQ_STAT: rd_word[GPIO_W-1:0] = irq_stat_q;
`endif
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_data_o <= '0;
    end else if (rd) begin
      gpio_data_o <= rd_word;
    end
  end

  assign gpio_pins_o = out_q;
  assign gpio_oe_o   = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (GPIO_W=16) with a register-level reference model.
// IRQ scenarios run only when GPIO_IRQ_EN is defined for the whole build.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        gpio_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] wmem_data;
  logic [31:0] gpio_data;
  logic [15:0] pins_in;
  logic [15:0] pins_out;
  logic [15:0] oe;
  logic        irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          run   = 1'b0;

  gpio_ctrl #(.GPIO_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_en_i   (gpio_en),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .wmem_data_i (wmem_data),
    .gpio_data_o (gpio_data),
    .gpio_pins_i (pins_in),
    .gpio_pins_o (pins_out),
    .gpio_oe_o   (oe),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus a history of pin samples taken at each edge.
  // samp[0] = pins at the last edge, samp[1] = what IN shows now, samp[2] = the value before that.
  logic [15:0] m_out, m_dir, m_en, m_rise, m_stat;
  logic [31:0] m_data;
  logic [15:0] samp [0:2];

  function automatic logic [15:0] model_read(input int unsigned off);
    case (off)
      0: return m_out;
      1: return m_dir;
      2: return samp[1];
`ifdef GPIO_IRQ_EN
      3: return m_en;
      4: return m_rise;
      5: return m_stat;
`endif
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int unsigned off;
    logic [15:0] wd, hit;
    if (rst) begin
      m_out = '0; m_dir = '0; m_en = '0; m_rise = '0; m_stat = '0; m_data = '0;
      for (int i = 0; i < 3; i++) samp[i] = '0;
    end else begin
      off = int'(mem_addr[4:2]);
      wd  = wmem_data[15:0];
      if (gpio_en && !mem_we) m_data = {16'h0, model_read(off)};
      hit = '0;
      for (int i = 0; i < 16; i++) begin
        if (m_rise[i]) hit[i] = samp[1][i] && !samp[2][i];
        else           hit[i] = !samp[1][i] && samp[2][i];
      end
`ifdef GPIO_IRQ_EN
      if (gpio_en && mem_we && off == 5) m_stat = m_stat & ~wd;
      m_stat = m_stat | hit;
`endif
      if (gpio_en && mem_we) begin
        case (off)
          0: m_out = wd;
          1: m_dir = wd;
`ifdef GPIO_IRQ_EN
          3: m_en = wd;
          4: m_rise = wd;
`endif
          6: m_out = m_out | wd;
          7: m_out = m_out & ~wd;
          default: ;
        endcase
      end
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = pins_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model data", gpio_data, m_data);
      check("model pins_o", {16'h0, pins_out}, {16'h0, m_out});
      check("model oe", {16'h0, oe}, {16'h0, m_dir});
      check("model irq", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
    end
  end

  function automatic logic [31:0] mk_addr(input int unsigned off);
    logic [31:0] a;
    a = $urandom;
    a[31:29] = 3'b010;
    a[4:2] = off[2:0];
    return a;
  endfunction

  task automatic wr(input int unsigned off, input logic [31:0] d);
    gpio_en = 1'b1; mem_we = 1'b1; mem_addr = mk_addr(off); wmem_data = d;
    @(posedge clk); #1;
  endtask

  task automatic rd(input int unsigned off);
    gpio_en = 1'b1; mem_we = 1'b0; mem_addr = mk_addr(off); wmem_data = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    gpio_en = 1'b0; mem_we = 1'b0; mem_addr = $urandom; wmem_data = $urandom;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; gpio_en = 1'b0; mem_we = 1'b0; mem_addr = '0; wmem_data = '0; pins_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; run = 1'b1;

    for (int unsigned o = 0; o < 8; o++) begin
      rd(o);
      check("reset read", gpio_data, 32'h0);
    end
    check("reset irq", {31'h0, irq}, 32'h0);

    wr(0, 32'hFFFF_A5A5);
    rd(0);  check("OUT write", gpio_data, 32'h0000_A5A5);
    wr(6, 32'h0000_000F);
    rd(0);  check("OUT_SET", gpio_data, 32'h0000_A5AF);
    wr(7, 32'h0000_00A0);
    rd(0);  check("OUT_CLR", gpio_data, 32'h0000_A50F);
    rd(6);  check("OUT_SET reads 0", gpio_data, 32'h0);
    rd(7);  check("OUT_CLR reads 0", gpio_data, 32'h0);
    check("pins_o", {16'h0, pins_out}, 32'h0000_A50F);
    wr(1, 32'h0000_00FF);
    check("oe after DIR", {16'h0, oe}, 32'h0000_00FF);
    wr(2, 32'h0000_FFFF);
    rd(2);  check("IN ignores write", gpio_data, 32'h0);
    wr(1, 32'h0000_0F0F);
    rd(1);  check("DIR read after write", gpio_data, 32'h0000_0F0F);
    check("write keeps data", gpio_data, 32'h0000_0F0F);
    wr(0, 32'h0000_1111);
    check("write leaves data", gpio_data, 32'h0000_0F0F);

    @(negedge clk); pins_in = 16'h1234;
    rd(2);  check("IN at E", gpio_data, 32'h0);
    rd(2);  check("IN at E+1", gpio_data, 32'h0);
    rd(2);  check("IN at E+2", gpio_data, 32'h0000_1234);

`ifdef GPIO_IRQ_EN
    @(negedge clk); pins_in = 16'h0000;
    idle(4);
    wr(5, 32'h0000_FFFF);
    wr(3, 32'h0000_0001);
    wr(4, 32'h0000_0001);
    rd(5);  check("stat cleared", gpio_data, 32'h0);
    @(negedge clk); pins_in = 16'h0001;
    idle(2);
    check("irq not yet at E+1", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq at E+2", {31'h0, irq}, 32'h1);
    rd(5);  check("stat rise", gpio_data, 32'h0000_0001);
    wr(5, 32'h0000_0001);
    check("irq after W1C", {31'h0, irq}, 32'h0);
    @(negedge clk); pins_in = 16'h0000;
    idle(4);
    check("no irq on fall", {31'h0, irq}, 32'h0);
    rd(5);  check("stat after fall", gpio_data, 32'h0);

    wr(3, 32'h0000_0008);
    wr(4, 32'h0000_0000);
    @(negedge clk); pins_in = 16'h0008;
    idle(4);
    @(negedge clk); pins_in = 16'h0000;
    idle(4);
    check("irq on fall pin3", {31'h0, irq}, 32'h1);
    @(negedge clk); pins_in = 16'h0008;
    idle(4);
    @(negedge clk); pins_in = 16'h0000;
    idle(2);
    wr(5, 32'h0000_0008);
    check("collision irq held", {31'h0, irq}, 32'h1);
    rd(5);  check("collision stat", gpio_data, 32'h0000_0008);
`else
    wr(3, 32'h0000_FFFF);
    wr(4, 32'h0000_FFFF);
    wr(5, 32'h0000_FFFF);
    @(negedge clk); pins_in = 16'hFFFF;
    idle(4);
    @(negedge clk); pins_in = 16'h0000;
    idle(4);
    rd(3);  check("no IRQ_EN reg", gpio_data, 32'h0);
    rd(4);  check("no IRQ_RISE reg", gpio_data, 32'h0);
    rd(5);  check("no IRQ_STAT reg", gpio_data, 32'h0);
    check("irq tied low", {31'h0, irq}, 32'h0);
    @(negedge clk); pins_in = 16'h00C3;
    idle(2);
    rd(2);  check("IN still works", gpio_data, 32'h0000_00C3);
`endif

    // Mid-cycle asynchronous reset during a write to OUT.
    wr(1, 32'h0000_00FF);
    rd(0);
    @(negedge clk);
    gpio_en = 1'b1; mem_we = 1'b1; mem_addr = mk_addr(0); wmem_data = 32'h0000_FFFF;
    #2 rst = 1'b1;
    #1;
    check("async rst pins_o", {16'h0, pins_out}, 32'h0);
    check("async rst oe", {16'h0, oe}, 32'h0);
    check("async rst data", gpio_data, 32'h0);
    check("async rst irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0; pins_in = 16'h0000;
    for (int unsigned o = 0; o < 8; o++) begin
      rd(o);
      check("post-reset read", gpio_data, 32'h0);
    end
    idle(2);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
